// File: rtl/btn_eventos_if.sv
// btn_eventos_if: debounced button levels in, command events and test-mode level out
interface btn_eventos_if;
  logic btn_salud;
  logic btn_hambre;
  logic btn_reset;
  logic btn_test;
  logic ev_curar;
  logic ev_alimentar;
  logic ev_reset;
  logic modo_test;
  logic ev_test_paso;
  modport master (
    output btn_salud, btn_hambre, btn_reset, btn_test,
    input  ev_curar, ev_alimentar, ev_reset, modo_test, ev_test_paso
  );
  modport slave (
    input  btn_salud, btn_hambre, btn_reset, btn_test,
    output ev_curar, ev_alimentar, ev_reset, modo_test, ev_test_paso
  );
endinterface

// File: rtl/btn_eventos.sv
// btn_eventos: turns debounced button levels into one-cycle command events and a test-mode level
module btn_eventos #(
  parameter int HOLD_CYC = 250_000_000
) (
  input logic clk,
  input logic rst,
  btn_eventos_if.slave bus
);
  localparam int CW = $clog2(HOLD_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] FULL = CW'(HOLD_CYC);
  typedef enum logic [1:0] {IDLE, COUNT, FIRED} st_t;
  logic [1:0] btn;
  logic [1:0] prev;
  logic p_salud;
  logic p_hambre;
  st_t st [2];
  st_t st_n [2];
  logic [CW-1:0] cnt [2];
  logic [CW-1:0] cnt_n [2];
  logic [1:0] fire;
  logic idle;
  logic curar_n;
  logic alim_n;
  logic modo_n;
  logic paso_n;
  // channel 0 is the reset button, channel 1 the test button
  assign btn = {bus.btn_test, bus.btn_reset};
  // previous samples load during reset too, so a button held through reset yields no rising edge
  always_ff @(posedge clk) begin
    p_salud <= bus.btn_salud;
    p_hambre <= bus.btn_hambre;
    prev <= btn;
  end
  // long-press channel state and hold counters
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      st[i] <= rst ? IDLE : st_n[i];
      cnt[i] <= rst ? '0 : cnt_n[i];
    end
  end
  // a press only starts counting if the other channel is idle; the counter saturates once fired
  always_comb begin
    st_n = st;
    cnt_n = cnt;
    fire = '0;
    for (int i = 0; i < 2; i++) begin
      case (st[i])
        IDLE: if (btn[i] && !prev[i] && st[1-i] == IDLE) begin
          st_n[i] = COUNT;
          cnt_n[i] = CW'(1);
        end
        COUNT: if (!btn[i]) st_n[i] = IDLE;
          else if (cnt[i] == LAST) begin
            st_n[i] = FIRED;
            cnt_n[i] = FULL;
            fire[i] = 1'b1;
          end else cnt_n[i] = cnt[i] + CW'(1);
        FIRED: if (!btn[i]) st_n[i] = IDLE;
        default: st_n[i] = IDLE;
      endcase
    end
  end
  // event decode: heal/feed only fire alone and while both long-press channels are idle
  always_comb begin
    idle = st[0] == IDLE && st[1] == IDLE;
    curar_n = bus.btn_salud && !p_salud && !bus.btn_hambre && !p_hambre && idle;
    alim_n = bus.btn_hambre && !p_hambre && !bus.btn_salud && !p_salud && idle;
    modo_n = fire[0] ? 1'b0 : fire[1] ? !bus.modo_test : bus.modo_test;
    paso_n = st[1] == COUNT && !btn[1] && bus.modo_test;
  end
  // registered outputs; a reset long press beats a simultaneous test toggle
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ev_curar <= 1'b0;
      bus.ev_alimentar <= 1'b0;
      bus.ev_reset <= 1'b0;
      bus.modo_test <= 1'b0;
      bus.ev_test_paso <= 1'b0;
    end else begin
      bus.ev_curar <= curar_n;
      bus.ev_alimentar <= alim_n;
      bus.ev_reset <= fire[0];
      bus.modo_test <= modo_n;
      bus.ev_test_paso <= paso_n;
    end
  end
endmodule

// File: tb/tb_btn_eventos.sv
// tb_btn_eventos: directed and random checks of btn_eventos against a run-length reference model
module tb_btn_eventos;
  localparam int HOLD = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_pass = 0;
  int n_chk = 0;
  int run_r = 0;
  int run_t = 0;
  logic ps, ph, pr, pt;
  logic modo_m = 1'b0;
  logic [4:0] exp_o = '0;
  logic [4:0] outs;
  btn_eventos_if bus();
  btn_eventos #(.HOLD_CYC(HOLD)) dut (.clk(clk), .rst(rst), .bus(bus));
  assign outs = {bus.ev_curar, bus.ev_alimentar, bus.ev_reset, bus.modo_test, bus.ev_test_paso};
  always #5 clk = ~clk;
  // run_x counts consecutive high samples of an accepted press (0 = no press), capped at HOLD
  task automatic model(input logic [3:0] b, input logic r);
    logic s, h, rb, t, cur, ali, fr, ft, paso;
    int ro, to;
    {s, h, rb, t} = b;
    {cur, ali, fr, ft, paso} = '0;
    if (r) begin
      run_r = 0;
      run_t = 0;
      modo_m = 1'b0;
    end else begin
      ro = run_r;
      to = run_t;
      cur = s && !ps && !h && !ph && ro == 0 && to == 0;
      ali = h && !ph && !s && !ps && ro == 0 && to == 0;
      if (ro == 0) run_r = (rb && !pr && to == 0) ? 1 : 0;
      else if (!rb) run_r = 0;
      else if (ro < HOLD) begin
        run_r = ro + 1;
        fr = run_r == HOLD;
      end
      if (to == 0) run_t = (t && !pt && ro == 0) ? 1 : 0;
      else if (!t) begin
        run_t = 0;
        paso = to < HOLD && modo_m;
      end else if (to < HOLD) begin
        run_t = to + 1;
        ft = run_t == HOLD;
      end
      modo_m = fr ? 1'b0 : ft ? !modo_m : modo_m;
    end
    {ps, ph, pr, pt} = b;
    exp_o = {cur, ali, fr, modo_m, paso};
  endtask
  // b = {salud, hambre, reset, test}
  task automatic cyc(input logic [3:0] b, input logic r);
    {bus.btn_salud, bus.btn_hambre, bus.btn_reset, bus.btn_test} = b;
    rst = r;
    @(posedge clk);
    model(b, r);
    #1;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(4'($urandom), 1'b1);
      n_chk++;
      if (outs !== 5'b0 || outs !== exp_o) $display("FAIL reset c%0d outs=%b exp=00000", i, outs);
      else n_pass++;
    end
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0000, 1'b0);
      n_chk++;
      if (outs !== exp_o) $display("FAIL reset_idle c%0d outs=%b exp=%b", i, outs, exp_o);
      else n_pass++;
    end
  endtask
  task automatic test_heal();
    int n = 0;
    int first = -1;
    for (int i = 0; i < 6; i++) begin
      cyc(i < 3 ? 4'b1000 : 4'b0000, 1'b0);
      n += int'(bus.ev_curar);
      if (bus.ev_curar && first < 0) first = i;
      n_chk++;
      if (outs !== exp_o) $display("FAIL heal c%0d outs=%b exp=%b", i, outs, exp_o);
      else n_pass++;
    end
    n_chk++;
    if (n !== 1 || first !== 0) $display("FAIL heal_pulse count=%0d at=%0d exp count=1 at=0", n, first);
    else n_pass++;
  endtask
  task automatic test_simultaneous();
    logic [3:0] seq [13] = '{4'b1100, 4'b1100, 4'b0000, 4'b0100, 4'b0100, 4'b1100, 4'b1100,
                             4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
    int n [3] = '{0, 0, 0};
    for (int i = 0; i < 13; i++) begin
      cyc(seq[i], 1'b0);
      n[i < 3 ? 0 : i < 8 ? 1 : 2] += int'(bus.ev_curar);
      n_chk++;
      if (outs !== exp_o) $display("FAIL simul c%0d outs=%b exp=%b", i, outs, exp_o);
      else n_pass++;
    end
    n_chk++;
    if (n[0] !== 0 || n[1] !== 0 || n[2] !== 1)
      $display("FAIL simul_counts got %0d/%0d/%0d exp 0/0/1", n[0], n[1], n[2]);
    else n_pass++;
  endtask
  task automatic test_test_mode();
    logic m7 = 1'b0;
    int p = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(i < 8 ? 4'b0001 : 4'b0000, 1'b0);
      if (i == 6) m7 = bus.modo_test;
      n_chk++;
      if (outs !== exp_o) $display("FAIL tlong c%0d outs=%b exp=%b", i, outs, exp_o);
      else n_pass++;
    end
    n_chk++;
    if ({m7, bus.modo_test} !== 2'b01) $display("FAIL tlong_modo got %b exp 01", {m7, bus.modo_test});
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      cyc(i < 3 ? 4'b0001 : 4'b0000, 1'b0);
      p += int'(bus.ev_test_paso);
      n_chk++;
      if (outs !== exp_o) $display("FAIL tshort c%0d outs=%b exp=%b", i, outs, exp_o);
      else n_pass++;
    end
    n_chk++;
    if (p !== 1 || bus.modo_test !== 1'b1) $display("FAIL tshort_paso got %0d modo=%b exp 1 modo=1", p, bus.modo_test);
    else n_pass++;
    p = 0;
    for (int i = 0; i < 22; i++) begin
      cyc(i < 20 ? 4'b0001 : 4'b0000, 1'b0);
      p += int'(bus.ev_test_paso);
      n_chk++;
      if (outs !== exp_o) $display("FAIL tlong2 c%0d outs=%b exp=%b", i, outs, exp_o);
      else n_pass++;
    end
    n_chk++;
    if (p !== 0 || bus.modo_test !== 1'b0) $display("FAIL tlong2_modo paso=%0d modo=%b exp 0 0", p, bus.modo_test);
    else n_pass++;
  endtask
  task automatic test_reset_long();
    int n = 0;
    for (int i = 0; i < 9; i++) cyc(i < 8 ? 4'b0001 : 4'b0000, 1'b0);
    n_chk++;
    if (bus.modo_test !== 1'b1) $display("FAIL rlong_pre modo=%b exp 1", bus.modo_test);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      cyc(i < 8 ? 4'b0010 : 4'b0000, 1'b0);
      if (i == 7) begin
        n_chk++;
        if ({bus.ev_reset, bus.modo_test} !== 2'b10) $display("FAIL rlong_fire got %b exp 10", {bus.ev_reset, bus.modo_test});
        else n_pass++;
      end
      n_chk++;
      if (outs !== exp_o) $display("FAIL rlong c%0d outs=%b exp=%b", i, outs, exp_o);
      else n_pass++;
    end
    for (int i = 0; i < 9; i++) begin
      cyc(i < 7 ? 4'b0010 : 4'b0000, 1'b0);
      n += int'(bus.ev_reset);
      n_chk++;
      if (outs !== exp_o) $display("FAIL rshort c%0d outs=%b exp=%b", i, outs, exp_o);
      else n_pass++;
    end
    n_chk++;
    if (n !== 0) $display("FAIL rshort_count got %0d exp 0", n);
    else n_pass++;
  endtask
  task automatic test_rst_midcount();
    int a = 0;
    int r = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(i < 5 ? 4'b0100 : 4'b0000, i < 2);
      a += int'(bus.ev_alimentar);
      n_chk++;
      if (outs !== exp_o) $display("FAIL rsthold c%0d outs=%b exp=%b", i, outs, exp_o);
      else n_pass++;
    end
    for (int i = 0; i < 18; i++) begin
      cyc(i < 16 ? 4'b0010 : 4'b0000, i == 5);
      r += int'(bus.ev_reset);
      n_chk++;
      if (outs !== exp_o) $display("FAIL rstmid c%0d outs=%b exp=%b", i, outs, exp_o);
      else n_pass++;
    end
    n_chk++;
    if (a !== 0 || r !== 0) $display("FAIL rstmid_counts alim=%0d reset=%0d exp 0 0", a, r);
    else n_pass++;
  endtask
  task automatic test_overlap();
    int n = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(i == 2 || i == 3 ? 4'b1010 : i < 6 ? 4'b0010 : 4'b0000, 1'b0);
      n += int'(bus.ev_curar);
      n_chk++;
      if (outs !== exp_o) $display("FAIL ovl_heal c%0d outs=%b exp=%b", i, outs, exp_o);
      else n_pass++;
    end
    n_chk++;
    if (n !== 0) $display("FAIL ovl_heal_count got %0d exp 0", n);
    else n_pass++;
    for (int i = 0; i < 9; i++) cyc(i < 8 ? 4'b0001 : 4'b0000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(i < 8 ? 4'b0011 : 4'b0000, 1'b0);
      if (i == 7) begin
        n_chk++;
        if ({bus.ev_reset, bus.modo_test} !== 2'b10) $display("FAIL ovl_both got %b exp 10", {bus.ev_reset, bus.modo_test});
        else n_pass++;
      end
      n_chk++;
      if (outs !== exp_o) $display("FAIL ovl_both c%0d outs=%b exp=%b", i, outs, exp_o);
      else n_pass++;
    end
  endtask
  task automatic test_random();
    logic [3:0] b = '0;
    for (int i = 0; i < 4000; i++) begin
      for (int k = 0; k < 4; k++) if ($urandom_range(15) == 0) b[k] = !b[k];
      cyc(b, $urandom_range(599) == 0);
      n_chk++;
      if (outs !== exp_o) $display("FAIL random c%0d in=%b outs=%b exp=%b", i, b, outs, exp_o);
      else n_pass++;
    end
  endtask
  initial begin
    {bus.btn_salud, bus.btn_hambre, bus.btn_reset, bus.btn_test} = '0;
    test_reset();
    test_heal();
    test_simultaneous();
    test_test_mode();
    test_reset_long();
    test_rst_midcount();
    test_overlap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
